// File: rtl/fb_scanout_controller.sv
// fb_scanout_controller: prefetches display rows from SRAM into a ping-pong row buffer and streams palette indices;
// clears and swaps the frame buffer in vertical blanking. SCANOUT_LINE_DOUBLE_EN shows each SRAM row on two lines.
module fb_scanout_controller #(
  parameter int BPP = 4,
  parameter int WORD_W = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL = 525,
  parameter int COL_W = 8,
  parameter int ROW_W = 10,
  parameter int RD_LAT = 1,
  parameter logic [WORD_W-1:0] CLEAR_WORD = WORD_W'(16'h1111)
) (
  input  logic                     Clk,
  input  logic                     Reset_N,
  input  logic                     EN,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic                     hsync_n,
  input  logic                     frame_start,
  input  logic                     clear_start,
  output logic                     clear_done,
  output logic                     step_done,
  output logic                     even_frame,
  output logic [BPP-1:0]           pixel_idx,
  output logic [COL_W+ROW_W+1:0]   SRAM_ADDRESS,
  output logic [WORD_W-1:0]        Data_to_SRAM,
  input  logic [WORD_W-1:0]        Data_from_SRAM,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N
);
  localparam int PPW = WORD_W / BPP;
  localparam int WPR = H_ACTIVE / PPW;
  localparam int WI = $clog2(WPR);
  localparam int AW = COL_W + ROW_W;
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VT = 10'(V_TOTAL);
`ifdef SCANOUT_LINE_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif
  typedef enum logic [3:0] {IDLE, READ_SYNC, READ, READ_DRAIN, ROW_DONE, CLEAR_SYNC, CLEAR, CLEAR_WAIT, CLEAR_DONE} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic frame_pend, bank, wait0, tog;
  logic [1:0] dcnt;
  logic [RD_LAT-1:0] pv;
  logic [WI-1:0] ps [RD_LAT];
  logic [WORD_W-1:0] rbuf [2**(WI+1)];
  logic [9:0] ny, nrow;
  logic [ROW_W-1:0] srow;
  logic skip, win, sd_row, flip, front;
  logic [WORD_W-1:0] word;
  assign SRAM_ADDRESS = {1'b0, even_frame, cnt};
  always_comb begin
    ny = DrawY + 10'd1;
    nrow = (ny == VT) ? 10'd0 : ny;
    srow = DBL ? ROW_W'(nrow >> 1) : ROW_W'(nrow);
    skip = nrow >= VA || (DBL && nrow[0]);
    win = DrawY > VA && DrawY < VA + 10'd10;
    sd_row = DrawX < 10'd150 && !win;
    // the swap edge itself already shows the freshly loaded row
    flip = state == ROW_DONE && EN && wait0 && tog && DrawX == 10'd0;
    front = bank ^ flip;
    word = rbuf[{front, WI'(DrawX / 10'(PPW))}] >> (BPP * (DrawX % 10'(PPW)));
  end
  always_ff @(posedge Clk) begin
    ps[0] <= cnt[WI-1:0];
    for (int i = 1; i < RD_LAT; i++) ps[i] <= ps[i-1];
    if (pv[RD_LAT-1] && EN) rbuf[{~bank, ps[RD_LAT-1]}] <= Data_from_SRAM;
  end
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      state <= IDLE;
      cnt <= '0;
      frame_pend <= 1'b0;
      bank <= 1'b0;
      wait0 <= 1'b0;
      tog <= 1'b0;
      dcnt <= '0;
      pv <= '0;
      even_frame <= 1'b0;
      pixel_idx <= '0;
      clear_done <= 1'b0;
      step_done <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      Data_to_SRAM <= '0;
    end else begin
      frame_pend <= frame_start || (frame_pend && !(state == IDLE && EN));
      pv <= RD_LAT'({pv, state == READ && EN});
      pixel_idx <= (DrawX < HA) ? word[BPP-1:0] : '0;
      step_done <= state == IDLE || (state == ROW_DONE && sd_row);
      if (flip) bank <= ~bank;
      if (EN)
        case (state)
          IDLE: if (frame_pend) state <= READ_SYNC;
          READ_SYNC:
            if (skip) begin
              state <= ROW_DONE;
              wait0 <= 1'b1;
              tog <= !(DBL && nrow[0]);
            end else begin
              state <= READ;
              SRAM_OE_N <= 1'b0;
              cnt <= {srow, COL_W'(0)};
            end
          READ:
            if (cnt[COL_W-1:0] == COL_W'(WPR-1)) begin
              state <= READ_DRAIN;
              dcnt <= '0;
            end else cnt[COL_W-1:0] <= cnt[COL_W-1:0] + COL_W'(1);
          READ_DRAIN:
            if (dcnt == 2'(RD_LAT-1)) begin
              state <= ROW_DONE;
              SRAM_OE_N <= 1'b1;
              wait0 <= 1'b1;
              tog <= 1'b1;
            end else dcnt <= dcnt + 2'd1;
          ROW_DONE: begin
            if (wait0 && DrawX == 10'd0) wait0 <= 1'b0;
            if (win && clear_start) state <= CLEAR_SYNC;
            else if (!wait0 && !hsync_n) state <= READ_SYNC;
          end
          CLEAR_SYNC: begin
            state <= CLEAR;
            SRAM_WE_N <= 1'b0;
            Data_to_SRAM <= CLEAR_WORD;
            cnt <= '0;
          end
          CLEAR: if (&cnt) state <= CLEAR_WAIT; else cnt <= cnt + AW'(1);
          CLEAR_WAIT: begin
            state <= CLEAR_DONE;
            SRAM_WE_N <= 1'b1;
            Data_to_SRAM <= '0;
            even_frame <= ~even_frame;
            clear_done <= 1'b1;
          end
          CLEAR_DONE:
            if (!clear_start) begin
              state <= IDLE;
              clear_done <= 1'b0;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_fb_scanout_controller.sv
// tb_fb_scanout_controller: directed vector bench with a latency-accurate SRAM model.
module tb_fb_scanout_controller;
  localparam int RL = 2;
  localparam int CW = 8;
  localparam int RW = 6;
  localparam int AW = CW + RW;
  localparam int NW = 2 ** AW;
`ifdef SCANOUT_LINE_DOUBLE_EN
  localparam int R10 = 5, R11 = 5;
`else
  localparam int R10 = 10, R11 = 11;
`endif
  typedef struct { logic [9:0] x; logic [3:0] pix; logic sd; } vec_t;
  logic Clk = 0, Reset_N = 0, EN = 1, hsync_n = 1, frame_start = 0, clear_start = 0;
  logic [9:0] DrawX = 0, DrawY = 0;
  logic clear_done, step_done, even_frame, SRAM_OE_N, SRAM_WE_N;
  logic [3:0] pixel_idx;
  logic [AW+1:0] SRAM_ADDRESS;
  logic [15:0] Data_to_SRAM, Data_from_SRAM = 0;
  int nv = 0, nbad = 0, mode = 0, wn = 0, wbad = 0;
  logic [AW+1:0] ah [RL+1];
  logic [AW+1:0] wlast;
  logic [AW+1:0] rd_a [$];
  vec_t tv [$];
  fb_scanout_controller #(.BPP(4), .WORD_W(16), .COL_W(CW), .ROW_W(RW), .RD_LAT(RL)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .EN(EN), .DrawX(DrawX), .DrawY(DrawY), .hsync_n(hsync_n),
    .frame_start(frame_start), .clear_start(clear_start), .clear_done(clear_done), .step_done(step_done),
    .even_frame(even_frame), .pixel_idx(pixel_idx), .SRAM_ADDRESS(SRAM_ADDRESS), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N));
  always #5 Clk = ~Clk;
  function automatic logic [15:0] sdata(input logic [AW+1:0] a);
    logic [7:0] c, r;
    c = a[7:0];
    r = 8'(a[AW-1:CW]);
    return mode == 0 ? 16'(c) : mode == 1 ? 16'hABCD + 16'(c) * 16'h1111 : {r, c};
  endfunction
  // data presented in cycle m answers the address issued in cycle m-RL
  always @(negedge Clk) begin
    for (int i = RL; i > 0; i--) ah[i] = ah[i-1];
    ah[0] = SRAM_ADDRESS;
    Data_from_SRAM = sdata(ah[RL]);
    if (!SRAM_OE_N && (rd_a.size() == 0 || SRAM_ADDRESS != rd_a[rd_a.size()-1])) rd_a.push_back(SRAM_ADDRESS);
    if (!SRAM_WE_N && (wn == 0 || SRAM_ADDRESS != wlast)) begin
      if (SRAM_ADDRESS != (AW+2)'(wn) || Data_to_SRAM != 16'h1111) wbad++;
      wlast = SRAM_ADDRESS;
      wn++;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nv++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic add(input int x, input int pix, input logic sd);
    vec_t v;
    v.x = 10'(x);
    v.pix = 4'(pix);
    v.sd = sd;
    tv.push_back(v);
  endtask
  task automatic run_vecs(input string nm);
    for (int i = 0; i < tv.size(); i++) begin
      DrawX = tv[i].x;
      cyc(1);
      chk($sformatf("%s_pix_x%0d", nm, tv[i].x), 32'(pixel_idx), 32'(tv[i].pix));
      chk($sformatf("%s_sd_x%0d", nm, tv[i].x), 32'(step_done), 32'(tv[i].sd));
    end
    tv.delete();
  endtask
  task automatic wait_read(input string nm);
    logic seen;
    seen = 0;
    for (int t = 0; t < 600; t++) begin
      cyc(1);
      if (!SRAM_OE_N) seen = 1;
      else if (seen) break;
    end
    chk(nm, 32'(seen && SRAM_OE_N), 32'd1);
  endtask
  task automatic pulse_frame;
    frame_start = 1;
    cyc(1);
    frame_start = 0;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_oe"}, 32'(SRAM_OE_N), 1);
    chk({nm, "_we"}, 32'(SRAM_WE_N), 1);
    chk({nm, "_addr"}, 32'(SRAM_ADDRESS), 0);
    chk({nm, "_wdata"}, 32'(Data_to_SRAM), 0);
    chk({nm, "_sd"}, 32'(step_done), 1);
    chk({nm, "_cd"}, 32'(clear_done), 0);
    chk({nm, "_ef"}, 32'(even_frame), 0);
    chk({nm, "_pix"}, 32'(pixel_idx), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int rbad;
    cyc(2);
    chk_reset("rst");
    Reset_N = 1;
    cyc(2);
    DrawY = 524;
    DrawX = 700;
    rd_a.delete();
    pulse_frame();
    wait_read("row0_read");
    chk("row0_cnt", rd_a.size(), 160);
    rbad = 0;
    for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] != (AW+2)'(i)) rbad++;
    chk("row0_addrs", rbad, 0);
    DrawY = 0;
    add(0, 0, 1); add(3, 0, 1); add(4, 1, 1); add(5, 0, 1); add(8, 2, 1); add(149, 2, 1);
    add(150, 0, 0); add(636, 15, 0); add(637, 9, 0); add(639, 0, 0); add(640, 0, 0); add(799, 0, 0);
    run_vecs("row0");
    mode = 1;
    DrawX = 700;
    EN = 0;
    hsync_n = 0;
    cyc(5);
    chk("en_freeze_oe", 32'(SRAM_OE_N), 1);
    EN = 1;
    rd_a.delete();
    wait_read("row1_read");
    chk("row1_first", 32'(rd_a[0]), 32'(1 << CW));
    hsync_n = 1;
    DrawY = 1;
    add(0, 13, 1); add(1, 12, 1); add(2, 11, 1); add(3, 10, 1); add(4, 14, 1); add(7, 11, 1); add(600, 3, 0);
    run_vecs("abcd");
    DrawX = 7;
    cyc(1);
    hsync_n = 0;
    for (int t = 0; t < 20 && SRAM_OE_N; t++) cyc(1);
    chk("midread_pix", 32'(pixel_idx), 11);
    chk("midread_oe", 32'(SRAM_OE_N), 0);
    cyc(10);
    Reset_N = 0;
    #1;
    chk_reset("async_rst");
    cyc(2);
    Reset_N = 1;
    hsync_n = 1;
    DrawX = 700;
    cyc(3);
    chk("post_rst_sd", 32'(step_done), 1);
    chk("post_rst_oe", 32'(SRAM_OE_N), 1);
    DrawY = 495;
    clear_start = 1;
    rd_a.delete();
    pulse_frame();
    cyc(20);
    chk("noclr_writes", wn, 0);
    chk("noclr_ef", 32'(even_frame), 0);
    chk("noclr_cd", 32'(clear_done), 0);
    DrawY = 482;
    for (int t = 0; t < NW + 100 && !clear_done; t++) cyc(1);
    chk("clr_done", 32'(clear_done), 1);
    chk("clr_writes", wn, NW);
    chk("clr_bad", wbad, 0);
    chk("clr_ef", 32'(even_frame), 1);
    chk("clr_noreads", rd_a.size(), 0);
    cyc(5);
    chk("clr_done_hold", 32'(clear_done), 1);
    clear_start = 0;
    cyc(2);
    chk("clr_done_drop", 32'(clear_done), 0);
    chk("clr_idle_sd", 32'(step_done), 1);
    mode = 2;
    DrawY = 9;
    rd_a.delete();
    pulse_frame();
    wait_read("l10_read");
    chk("l10_cnt", rd_a.size(), 160);
    chk("l10_first", 32'(rd_a[0]), 32'((1 << AW) + (R10 << CW)));
    DrawY = 10;
    add(0, 0, 1); add(2, R10, 1); add(3, 0, 1); add(4, 1, 1); add(6, R10, 1); add(400, 4, 0); add(401, 6, 0);
    run_vecs("l10");
    DrawX = 700;
    hsync_n = 0;
    rd_a.delete();
`ifdef SCANOUT_LINE_DOUBLE_EN
    cyc(300);
    chk("l11_noread", rd_a.size(), 0);
`else
    wait_read("l11_read");
    chk("l11_first", 32'(rd_a[0]), 32'((1 << AW) + (R11 << CW)));
`endif
    hsync_n = 1;
    DrawY = 11;
    add(0, 0, 1); add(2, R11, 1); add(3, 0, 1); add(4, 1, 1); add(6, R11, 1); add(400, 4, 0); add(401, 6, 0);
    run_vecs("l11");
    $display("== %0d vectors applied, %0d miscompares ==", nv, nbad);
    $finish;
  end
endmodule
